seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller driving DIGITS common-anode-select lines from a packed hex value, with frame-synchronous value update, hex glyphs, leading-zero blanking, per-digit decimal point, per-digit blink and PWM brightness. Sits between the datapath's display registers and the board's segment/anode pins. Replaces the fixed 4-digit, decimal-only scanner.

---
 rtl/seg7_pkg.sv | 58 +++++
 rtl/seg7_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: glyph constants,
// segment bit positions and the hex nibble to glyph mapping.
package seg7_pkg;

    // Bit positions inside the 8-bit seg bus (bit7 = decimal point, a..g below it)
    localparam int SEG_DP_BIT = 7;
    localparam int SEG_A_BIT  = 6;
    localparam int SEG_B_BIT  = 5;
    localparam int SEG_C_BIT  = 4;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 2;
    localparam int SEG_F_BIT  = 1;
    localparam int SEG_G_BIT  = 0;

    // Glyphs as a..g (bit6 = a, bit0 = g), active-high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Hex nibble to a..g glyph
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to 7-segment glyph decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Table lookup kept in the package so every user shares one glyph set
    always_comb begin
        glyph = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: prescaled digit scan, frame-synchronous value
// update, leading-zero blanking, per-digit dp/enable/blink and PWM dimming.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 524288,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] pwm;
    logic [BLK_W-1:0]    blk_cnt;
    logic                blink_on;
    logic [4*DIGITS-1:0] pending;
    logic [4*DIGITS-1:0] shadow;

    logic                tick;
    logic                wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_en;
    logic                cur_blink;
    logic                cur_lz;
    logic                upper_zero;
    logic [6:0]          glyph;
    logic                lit;
    logic [7:0]          seg_next;

    assign tick = (presc == PRE_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Slot prescaler: one tick per SCAN_DIV clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // Digit index walks 0..DIGITS-1 and wraps, one step per tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idx <= '0;
        else if (tick)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    // Free-running PWM phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm <= '0;
        else     pwm <= pwm + 1'b1;
    end

    // Blink phase flips after every BLINK_FRAMES completed frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt  <= '0;
            blink_on <= 1'b1;
        end else if (wrap) begin
            if (blk_cnt == BLK_LAST) begin
                blk_cnt  <= '0;
                blink_on <= ~blink_on;
            end else begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end
    end

    // Double-buffered value: loads land in pending, the frame wrap commits them
    // so a frame never shows a mix of old and new digits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            shadow  <= '0;
            busy    <= 1'b0;
        end else if (wrap) begin
            shadow <= load ? value : pending;
            if (load) pending <= value;
            busy   <= 1'b0;
        end else if (load) begin
            pending <= value;
            busy    <= 1'b1;
        end
    end

    // Select the current digit's attributes; upper_zero tracks whether every
    // nibble from the top down to this one is zero (leading-zero run)
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        cur_blink  = 1'b0;
        cur_lz     = 1'b0;
        upper_zero = blank_lz;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                cur_nib   = shadow[4*i +: 4];
                cur_dp    = dp_mask[i];
                cur_en    = digit_en[i];
                cur_blink = blink_mask[i];
                cur_lz    = upper_zero && (i != 0);
            end
        end
    end

    seg7_decode u_decode (
        .nibble (cur_nib),
        .glyph  (glyph)
    );

    // Lit only when enabled, inside the PWM on-window and not in a blink-off phase
    always_comb begin
        lit                  = cur_en && (pwm <= brightness) && !(cur_blink && !blink_on);
        seg_next             = 8'h00;
        seg_next[6:0]        = cur_lz ? SEG_BLANK : glyph;
        seg_next[SEG_DP_BIT] = cur_dp;
    end

    // Output register; segments are driven dark whenever no anode is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= 8'h00;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= lit ? seg_next : 8'h00;
            an         <= lit ? (DIGITS'(1) << idx) : '0;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl against a cycle-count based
// reference model (DIGITS=4, SCAN_DIV=4, BRIGHT_W=4, BLINK_FRAMES=2).
module tb_seg7_scan_ctrl;

    localparam int D     = 4;
    localparam int SD    = 4;
    localparam int BW    = 4;
    localparam int BF    = 2;
    localparam int FRAME = D * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  blink_mask = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;                 // clock edges since reset release
    logic [15:0] pend_m = '0;
    logic [15:0] shad_m = '0;
    logic        busy_m = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .DIGITS       (D),
        .SCAN_DIV     (SD),
        .BRIGHT_W     (BW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .dp_mask    (dp_mask),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .seg        (seg),
        .an         (an),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] glyph_of(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1111110;  4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;  4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;  4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;  4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;  4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;  4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;  4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;  default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        if (obs !== expd) begin
            n_errors++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", tag, k, obs, expd);
        end
    endtask

    // One clock: predict from elapsed cycles and current inputs, then compare
    task automatic step();
        int         idx;
        int         frames;
        bit         wrap;
        bit         blink_on;
        bit         lit;
        bit         lz;
        logic [3:0] nib;
        logic [7:0] seg_e;
        logic [3:0] an_e;
        logic       busy_e;
        idx      = (k / SD) % D;
        frames   = k / FRAME;
        wrap     = (k % FRAME) == FRAME - 1;
        blink_on = ((frames / BF) % 2) == 0;
        lit      = digit_en[idx] && ((k % (1 << BW)) <= int'(brightness))
                   && !(blink_mask[idx] && !blink_on);
        nib      = shad_m[4*idx +: 4];
        lz       = blank_lz && (idx != 0) && ((shad_m >> (4*idx)) == 16'h0);
        seg_e    = lit ? {dp_mask[idx], (lz ? 7'h00 : glyph_of(nib))} : 8'h00;
        an_e     = lit ? 4'(1 << idx) : 4'h0;
        busy_e   = wrap ? 1'b0 : (load ? 1'b1 : busy_m);
        @(posedge clk);
        #1;
        check("seg", 32'(seg), 32'(seg_e));
        check("an", 32'(an), 32'(an_e));
        check("frame_done", 32'(frame_done), 32'(wrap));
        check("busy", 32'(busy), 32'(busy_e));
        if (wrap) begin
            shad_m = load ? value : pend_m;
            if (load) pend_m = value;
        end else if (load) begin
            pend_m = value;
        end
        busy_m = busy_e;
        k++;
        load = 1'b0;
    endtask

    task automatic run_to(input int phase);
        while ((k % FRAME) != phase) step();
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_an", 32'(an), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        rst = 1'b0;

        // Full brightness hex scan of 12AF
        brightness = 4'hF;
        digit_en   = 4'hF;
        value      = 16'h12AF;
        load       = 1'b1;
        step();
        repeat (3 * FRAME) step();

        // Leading-zero blanking
        blank_lz = 1'b1;
        value    = 16'h0050;
        load     = 1'b1;
        step();
        repeat (2 * FRAME) step();
        value = 16'h0000;
        load  = 1'b1;
        step();
        repeat (2 * FRAME) step();

        // Mid-frame load, then load exactly on the wrap cycle
        blank_lz = 1'b0;
        run_to(5);
        value = 16'h1111;
        load  = 1'b1;
        step();
        repeat (FRAME) step();
        run_to(FRAME - 1);
        value = 16'h2345;
        load  = 1'b1;
        step();
        repeat (FRAME) step();

        // Dimming and a disabled digit
        brightness = 4'h3;
        digit_en   = 4'b1011;
        repeat (2 * FRAME) step();
        brightness = 4'hC;
        repeat (2 * FRAME) step();

        // Blink on digit 0 and a decimal point on digit 2
        brightness = 4'hF;
        digit_en   = 4'hF;
        blink_mask = 4'b0001;
        dp_mask    = 4'b0100;
        repeat (6 * FRAME) step();

        // Randomized traffic on every input
        repeat (3000) begin
            dp_mask    = 4'($urandom);
            digit_en   = 4'($urandom_range(0, 3) == 0 ? $urandom : 32'hF);
            blink_mask = 4'($urandom);
            blank_lz   = 1'($urandom);
            brightness = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                value = 16'($urandom);
                for (int n = 0; n < 4; n++)
                    if ($urandom_range(0, 1) == 0) value[4*n +: 4] = 4'h0;
                load = 1'b1;
            end
            step();
        end

        // Asynchronous reset mid-slot while an update is pending
        blink_mask = 4'h0;
        blank_lz   = 1'b0;
        brightness = 4'hF;
        digit_en   = 4'hF;
        run_to(6);
        value = 16'hABCD;
        load  = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_seg", 32'(seg), 32'h0);
        check("arst_an", 32'(an), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_frame_done", 32'(frame_done), 32'h0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        k      = 0;
        pend_m = '0;
        shad_m = '0;
        busy_m = 1'b0;
        repeat (3 * FRAME) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
